// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the external data-memory bus: FSM encoding,
// bus direction codes and default bus widths.
package micro_bus_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Index of the set bit in a 2-way one-hot grant (0 when bit 1 is clear).
   function automatic logic grant_idx(input logic [1:0] gnt);
      return gnt[1];
   endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Requester, completion and memory-side signals of the data bus arbiter.
// master = arbiter side, slave = requesters plus memory.
interface data_bus_arbiter_if
   import micro_bus_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              req0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              rw0;
   logic              ack0;

   logic              req1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              rw1;
   logic              ack1;

   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              busy;

   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rw;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      input  req0, addr0, wdata0, rw0,
      input  req1, addr1, wdata1, rw1,
      input  mem_rdata, mem_ready,
      output ack0, ack1, rdata, err, busy,
      output mem_en, mem_addr, mem_wdata, mem_rw
   );

   modport slave (
      output req0, addr0, wdata0, rw0,
      output req1, addr1, wdata1, rw1,
      output mem_rdata, mem_ready,
      input  ack0, ack1, rdata, err, busy,
      input  mem_en, mem_addr, mem_wdata, mem_rw
   );

endinterface

// File: rtl/data_bus_arbiter_rr_arbiter2.sv
// Combinational 2-way round-robin arbiter: one-hot grant, the requester
// that did not win last time takes a tie.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-requester arbiter/sequencer for the external data-memory bus: one
// registered access per grant, bounded wait for ready, one-cycle ack.
module data_bus_arbiter
   import micro_bus_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   data_bus_arbiter_if.master bus
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              rw;
   } req_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [1:0] grant;
   logic       last_grant;
   logic       owner;
   logic [7:0] cnt;
   logic       timeout_hit;
   logic       access_exit;
   req_t       req_in [2];
   req_t       req_sel;
   req_t       req_q;

   assign req_in[0] = '{addr: bus.addr0, wdata: bus.wdata0, rw: bus.rw0};
   assign req_in[1] = '{addr: bus.addr1, wdata: bus.wdata1, rw: bus.rw1};
   assign req_sel   = req_in[grant_idx(grant)];

   rr_arbiter2 u_arb (
      .req        ({bus.req1, bus.req0}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign timeout_hit = (cnt == CNT_LAST);
   // Ready wins over a timeout landing in the same cycle.
   assign access_exit = (state == ACCESS) && (bus.mem_ready || timeout_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (|grant) state_nxt = ACCESS;
         ACCESS:  if (access_exit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q      <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         bus.mem_en <= 1'b0;
         bus.rdata  <= '0;
         bus.err    <= 1'b0;
         bus.ack0   <= 1'b0;
         bus.ack1   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|grant) begin
                  req_q      <= req_sel;
                  owner      <= grant_idx(grant);
                  last_grant <= grant_idx(grant);
                  cnt        <= '0;
                  bus.mem_en <= 1'b1;
               end
            end
            ACCESS: begin
               if (access_exit) begin
                  bus.mem_en <= 1'b0;
                  bus.ack0   <= ~owner;
                  bus.ack1   <= owner;
                  if (bus.mem_ready) begin
                     bus.err <= 1'b0;
                     if (req_q.rw == RW_READ) bus.rdata <= bus.mem_rdata;
                  end else begin
                     bus.err   <= 1'b1;
                     bus.rdata <= '0;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               bus.ack0 <= 1'b0;
               bus.ack1 <= 1'b0;
               bus.err  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_addr  = req_q.addr;
   assign bus.mem_wdata = req_q.wdata;
   assign bus.mem_rw    = req_q.rw;
   assign bus.busy      = (state != IDLE);

   a_ack_onehot: assert property (@(posedge clk) disable iff (rst)
      !(bus.ack0 && bus.ack1));
   a_en_in_access: assert property (@(posedge clk) disable iff (rst)
      bus.mem_en |-> (state == ACCESS));
   a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(grant));

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus
// randomized transactions against a transaction-level reference model.
module tb_data_bus_arbiter;
   import micro_bus_pkg::*;

   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   logic       m_last  = 1'b1;
   logic [7:0] m_rdata = 8'h00;

   int ack_cyc_q [$];
   bit ack_own_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_bus_arbiter_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   data_bus_arbiter #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("ack_onehot", 32'(bus.ack0 & bus.ack1), 0);
         chk("en_when_idle", 32'(bus.mem_en & ~bus.busy), 0);
      end
      if (bus.ack0 || bus.ack1) begin
         ack_cyc_q.push_back(cyc);
         ack_own_q.push_back(bus.ack1);
      end
   end

   // One arbitrated access, entered and left at the negedge of an IDLE cycle.
   // d = access cycle in which memory raises ready (d >= TO means never).
   task automatic txn(input bit r0, input bit r1,
                      input logic [7:0] a0, input logic [7:0] w0, input bit rw0,
                      input logic [7:0] a1, input logic [7:0] w1, input bit rw1,
                      input int d, input logic [7:0] rd, input int rst_at);
      int         w, ens, start;
      bit         to, done;
      logic [7:0] ea, ew;
      bit         erw;
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_mem_en", 32'(bus.mem_en), 0);
      bus.req0 = r0; bus.addr0 = a0; bus.wdata0 = w0; bus.rw0 = rw0;
      bus.req1 = r1; bus.addr1 = a1; bus.wdata1 = w1; bus.rw1 = rw1;
      bus.mem_ready = 1'b0;
      w   = (r0 && r1) ? (m_last ? 0 : 1) : (r1 ? 1 : 0);
      ea  = (w == 1) ? a1 : a0;
      ew  = (w == 1) ? w1 : w0;
      erw = (w == 1) ? rw1 : rw0;
      m_last = (w == 1);
      to    = (d >= TO);
      start = cyc;
      ens   = 0;
      @(negedge clk);
      for (int k = 0; k < TO; k++) begin
         chk("acc_mem_en", 32'(bus.mem_en), 1);
         chk("acc_addr", 32'(bus.mem_addr), 32'(ea));
         chk("acc_wdata", 32'(bus.mem_wdata), 32'(ew));
         chk("acc_rw", 32'(bus.mem_rw), 32'(erw));
         chk("acc_noack", 32'({bus.ack0, bus.ack1}), 0);
         ens += int'(bus.mem_en);
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_mem_en", 32'(bus.mem_en), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_rdata", 32'(bus.rdata), 0);
            m_last  = 1'b1;
            m_rdata = 8'h00;
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            @(negedge clk);
            chk("rst_noack", 32'({bus.ack0, bus.ack1}), 0);
            rst = 1'b0;
            return;
         end
         // Requester inputs move after the grant; the access must not notice.
         bus.addr0 = 8'($urandom); bus.wdata0 = 8'($urandom); bus.rw0 = 1'($urandom);
         bus.addr1 = 8'($urandom); bus.wdata1 = 8'($urandom); bus.rw1 = 1'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            if (w == 0) bus.req0 = 1'b0;
            else        bus.req1 = 1'b0;
         end
         done = (k == d) || (k == TO - 1);
         bus.mem_ready = (k == d);
         bus.mem_rdata = (k == d) ? rd : 8'($urandom);
         @(negedge clk);
         if (done) break;
      end
      bus.mem_ready = 1'b0;
      if (to)           m_rdata = 8'h00;
      else if (erw == RW_READ) m_rdata = rd;
      chk("en_cycles", 32'(ens), to ? TO : d + 1);
      chk("ack0", 32'(bus.ack0), 32'(w == 0));
      chk("ack1", 32'(bus.ack1), 32'(w == 1));
      chk("err", 32'(bus.err), 32'(to));
      chk("rdata", 32'(bus.rdata), 32'(m_rdata));
      chk("done_mem_en", 32'(bus.mem_en), 0);
      chk("done_busy", 32'(bus.busy), 1);
      chk("latency", 32'(cyc - start), (to ? TO : d + 1) + 1);
      @(negedge clk);
      chk("post_ack", 32'({bus.ack0, bus.ack1}), 0);
      chk("post_err", 32'(bus.err), 0);
      chk("rdata_hold", 32'(bus.rdata), 32'(m_rdata));
   endtask

   task automatic idle_gap(input int n);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.mem_ready = 1'b1;
         bus.mem_rdata = 8'($urandom);
         @(negedge clk);
         chk("gap_busy", 32'(bus.busy), 0);
         chk("gap_mem_en", 32'(bus.mem_en), 0);
         chk("gap_rdata", 32'(bus.rdata), 32'(m_rdata));
      end
      bus.mem_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [1:0] r;
      int         d;
      rst = 1'b1;
      bus.req0 = 1'b1; bus.addr0 = 8'h77; bus.wdata0 = 8'h00; bus.rw0 = 1'b0;
      bus.req1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00; bus.rw1 = 1'b0;
      bus.mem_ready = 1'b0; bus.mem_rdata = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_ack", 32'({bus.ack0, bus.ack1}), 0);
      chk("rst_rdata0", 32'(bus.rdata), 0);
      chk("rst_err", 32'(bus.err), 0);
      chk("rst_busy0", 32'(bus.busy), 0);
      chk("rst_en0", 32'(bus.mem_en), 0);
      chk("rst_mem", 32'({bus.mem_addr, bus.mem_wdata, bus.mem_rw}), 0);
      rst = 1'b0;
      txn(1, 0, 8'h77, 8'h00, RW_READ, 8'h00, 8'h00, RW_READ, 0, 8'h11, -1);

      txn(1, 0, 8'h3C, 8'h00, RW_READ, 8'h00, 8'h00, RW_READ, 0, 8'hA5, -1);
      txn(0, 1, 8'h00, 8'h00, RW_READ, 8'h10, 8'h5A, RW_WRITE, 3, 8'hEE, -1);

      ack_cyc_q.delete();
      ack_own_q.delete();
      for (int i = 0; i < 4; i++)
         txn(1, 1, 8'($urandom), 8'($urandom), RW_READ,
             8'($urandom), 8'($urandom), RW_READ, 0, 8'($urandom), -1);
      chk("rr_count", 32'(ack_cyc_q.size()), 4);
      if (ack_cyc_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk("rr_order", 32'(ack_own_q[i]), 32'(i % 2));
         for (int i = 1; i < 4; i++) chk("rr_gap", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 3);
      end

      txn(1, 0, 8'h44, 8'h00, RW_READ, 8'h00, 8'h00, RW_READ, TO + 3, 8'h99, -1);
      txn(1, 0, 8'h45, 8'h00, RW_READ, 8'h00, 8'h00, RW_READ, 2, 8'h3E, -1);
      txn(0, 1, 8'h00, 8'h00, RW_READ, 8'h46, 8'h00, RW_READ, TO - 1, 8'h7B, -1);

      txn(1, 0, 8'h50, 8'h00, RW_READ, 8'h00, 8'h00, RW_READ, 5, 8'h00, 1);
      txn(1, 1, 8'h51, 8'h00, RW_READ, 8'h52, 8'h00, RW_READ, 0, 8'hC3, -1);

      for (int i = 0; i < 40; i++) begin
         r = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) d = $urandom_range(TO - 1, TO + 3);
         else                           d = $urandom_range(0, 4);
         txn(r[0], r[1], 8'($urandom), 8'($urandom), 1'($urandom),
             8'($urandom), 8'($urandom), 1'($urandom), d, 8'($urandom), -1);
         if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
